reorder_buffer: RTL

- In-order commit stage directly upstream of the register file.
- Allocates a 4-bit tag per issued instruction (tag 0 = `None`) and captures CDB results out of order.
- Drives the register file's submit_* port in program order, one instruction per cycle.
- On a mispredicted branch reaching the head, pulses predict_fail with the redirect PC and flushes itself.

---
 rtl/reorder_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags in program order, captures CDB results out of
// order, and commits one instruction per cycle with flush on mispredict.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_rd,
  output logic [3:0]        alloc_tag,
  output logic              full,
  input  logic              cdb_active,
  input  logic [3:0]        cdb_tag,
  input  logic [31:0]       cdb_val,
  input  logic [31:0]       cdb_addr,
  input  logic              cdb_mispredict,
  output logic              submit_valid_rs,
  output logic [3:0]        submit_tag_rs,
  output logic [31:0]       submit_val_rs,
  output logic [4:0]        submit_rd,
  output logic              predict_fail,
  output logic [31:0]       redirect_pc
);

  localparam logic [PTR_W:0]   LP_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LP_LAST  = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0]       r_busy, r_ready, r_mis;
  logic [DEPTH-1:0][4:0]  r_rd;
  logic [DEPTH-1:0][31:0] r_val, r_tgt;
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [PTR_W:0]         r_count;

  logic                   w_commit, w_flush, w_alloc, w_cdb_hit;
  logic [PTR_W-1:0]       w_cdb_idx, w_head_nxt, w_tail_nxt;

  assign alloc_tag = 4'(r_tail) + 4'd1;
  assign full      = (r_count == LP_DEPTH);

  assign w_head_nxt = (r_head == LP_LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == LP_LAST) ? '0 : r_tail + 1'b1;

  // Commit sees only pre-edge ready bits, so CDB data never bypasses into it.
  assign w_commit  = (r_count != '0) && r_ready[r_head] && !predict_fail;
  assign w_flush   = w_commit && r_mis[r_head];
  assign w_alloc   = alloc_req && !full && !predict_fail && !w_flush;
  assign w_cdb_idx = PTR_W'(cdb_tag - 4'd1);
  assign w_cdb_hit = cdb_active && !predict_fail && !w_flush &&
                     (cdb_tag != 4'd0) && ({1'b0, cdb_tag} <= 5'(DEPTH)) &&
                     r_busy[w_cdb_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy  <= '0;
      r_ready <= '0;
      r_mis   <= '0;
      r_rd    <= '0;
      r_val   <= '0;
      r_tgt   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_flush || (w_commit && r_head == PTR_W'(i))) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end else if (w_alloc && r_tail == PTR_W'(i)) begin
          r_busy[i]  <= 1'b1;
          r_ready[i] <= 1'b0;
          r_rd[i]    <= alloc_rd;
          r_mis[i]   <= 1'b0;
        end else if (w_cdb_hit && w_cdb_idx == PTR_W'(i)) begin
          r_val[i]   <= cdb_val;
          r_tgt[i]   <= cdb_addr;
          r_mis[i]   <= cdb_mispredict;
          r_ready[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      submit_valid_rs <= 1'b0;
      submit_tag_rs   <= '0;
      submit_val_rs   <= '0;
      submit_rd       <= '0;
      predict_fail    <= 1'b0;
      redirect_pc     <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_commit) r_head <= w_head_nxt;
        if (w_alloc)  r_tail <= w_tail_nxt;
        r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_commit);
      end
      submit_valid_rs <= w_commit;
      if (w_commit) begin
        submit_tag_rs <= 4'(r_head) + 4'd1;
        submit_val_rs <= r_val[r_head];
        submit_rd     <= r_rd[r_head];
      end
      predict_fail <= w_flush;
      if (w_flush) redirect_pc <= r_tgt[r_head];
    end
  end

endmodule
